// File: rtl/mp_adder_pkg.sv
// Shared types and constants for the multi-precision serial adder.
package mp_adder_pkg;

  localparam int N_W       = 16;
  localparam int IDX_W_DEF = 8;

  // Running group terms start as the identity of the G/P combine operator.
  localparam logic G_ACC_RST = 1'b0;
  localparam logic P_ACC_RST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mp_serial_adder16_core.sv
// a1csah16bits: 16-bit carry-select adder built from 4-bit blocks, with group
// generate/propagate outputs that ignore cin.
module a1csah16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        gen,
  output logic        prop
);

  localparam int BLK = 4;
  localparam int NB  = 16 / BLK;

  logic [4:0]    sum0 [NB];
  logic [4:0]    sum1 [NB];
  logic [NB-1:0] blk_p;

  // Each block precomputes both carry-in cases; only the select mux ripples.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    assign sum0[i]  = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
    assign sum1[i]  = sum0[i] + 5'd1;
    assign blk_p[i] = &(a[i*BLK +: BLK] ^ b[i*BLK +: BLK]);
  end

  always_comb begin
    logic c;
    logic g;
    logic p;
    s = '0;
    c = cin;
    g = 1'b0;
    p = 1'b1;
    for (int i = 0; i < NB; i++) begin
      s[i*BLK +: BLK] = c ? sum1[i][BLK-1:0] : sum0[i][BLK-1:0];
      c = c ? sum1[i][BLK] : sum0[i][BLK];
      g = sum0[i][BLK] | (blk_p[i] & g);
      p = blk_p[i] & p;
    end
    cout = c;
    gen  = g;
    prop = p;
  end

endmodule

// File: rtl/mp_serial_adder16.sv
// Multi-precision serial adder: one 16-bit word per cycle, LS word first.
// Optional subtract mode is enabled with the MP_SERIAL_ADDER16_SUB_EN macro.
module mp_serial_adder16
  import mp_adder_pkg::*;
#(
  parameter int n     = N_W,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_a,
  input  logic [n-1:0]     in_b,
  input  logic             in_cin,
  input  logic             in_last,
`ifdef MP_SERIAL_ADDER16_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out_s,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_gen,
  output logic             out_prop
);

  // Handshake: a word moves on a port when valid & ready are both high at a
  // rising edge; valid never depends on ready, and in_ready is the single
  // output stage being empty or draining this cycle.

  state_t state, state_d;
  logic   carry_q, g_acc, p_acc;
  logic   accept, first, sub_now;

  logic [n-1:0]     core_b, core_s;
  logic             core_cin, core_cout, core_gen, core_prop;
  logic             g_next, p_next;
  logic [IDX_W-1:0] idx_next;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign first    = (state == IDLE);

`ifdef MP_SERIAL_ADDER16_SUB_EN
  logic sub_q;
  assign sub_now = first ? in_sub : sub_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (accept && first) begin
      sub_q <= in_sub;
    end
  end
`else
  assign sub_now = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so word 0 forces the carry-in high.
  assign core_b   = sub_now ? ~in_b : in_b;
  assign core_cin = first ? (sub_now | in_cin) : carry_q;

  a1csah16bits u_core (
    .a    (in_a),
    .b    (core_b),
    .cin  (core_cin),
    .s    (core_s),
    .cout (core_cout),
    .gen  (core_gen),
    .prop (core_prop)
  );

  assign g_next   = core_gen | (core_prop & (first ? G_ACC_RST : g_acc));
  assign p_next   = core_prop & (first ? P_ACC_RST : p_acc);
  assign idx_next = first ? '0 : out_idx + IDX_W'(1);

  always_comb begin
    state_d = state;
    if (accept) begin
      state_d = in_last ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q   <= 1'b0;
      g_acc     <= G_ACC_RST;
      p_acc     <= P_ACC_RST;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_gen   <= 1'b0;
      out_prop  <= 1'b0;
    end else if (accept) begin
      carry_q   <= core_cout;
      g_acc     <= g_next;
      p_acc     <= p_next;
      out_valid <= 1'b1;
      out_s     <= core_s;
      out_idx   <= idx_next;
      out_last  <= in_last;
      out_cout  <= core_cout;
      out_gen   <= g_next;
      out_prop  <= p_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
